// File: rtl/difftest_sched_pkg.sv
// rtl/difftest_sched_pkg.sv - shared constants, types and round-robin helper for the overflow scheduler
//
// Contents:
//   OVF_W, COREID_W : default overflow vector and core id widths
//   ovf_vec_t       : one core's overflow vector
//   rr_next         : modular pointer increment (wraps n-1 -> 0)
package difftest_sched_pkg;

    localparam int OVF_W    = 64;
    localparam int COREID_W = 8;

    typedef logic [OVF_W-1:0] ovf_vec_t;

    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/difftest_mhpm_ovf_sched_if.sv
// rtl/difftest_mhpm_ovf_sched_if.sv - MhpmeventOverflow event channel (valid/ready) toward the difftest sink
//
// Signals:
//   out_valid             : event valid (scheduler -> sink)
//   out_ready             : sink accepts event this cycle (sink -> scheduler)
//   out_mhpmeventOverflow : issued overflow vector
//   out_coreid            : issued core id
// Modports: master = scheduler side, slave = sink side.
interface difftest_mhpm_ovf_sched_if #(
    parameter int OVF_W    = 64,
    parameter int COREID_W = 8
);
    logic                out_valid;
    logic                out_ready;
    logic [OVF_W-1:0]    out_mhpmeventOverflow;
    logic [COREID_W-1:0] out_coreid;

    modport master (
        output out_valid,
        output out_mhpmeventOverflow,
        output out_coreid,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_mhpmeventOverflow,
        input  out_coreid,
        output out_ready
    );
endinterface

// File: rtl/difftest_mhpm_ovf_sched_rr_arbiter.sv
// rtl/difftest_mhpm_ovf_sched_rr_arbiter.sv - combinational round-robin arbiter (first request at or after ptr)
//
// Ports:
//   req     in  N  request vector
//   ptr     in  W  highest-priority index for this cycle
//   gnt     out N  one-hot grant
//   gnt_idx out W  index of the granted requester
//   any     out 1  at least one request present
module rr_arbiter #(
    parameter  int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         any
);

    always_comb begin
        int j;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        j       = 0;
        // Walk N positions starting at ptr; the first hit wins and blocks the rest.
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && req[j]) begin
                any     = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = W'(j);
            end
        end
    end

endmodule

// File: rtl/difftest_mhpm_ovf_sched.sv
// rtl/difftest_mhpm_ovf_sched.sv - per-core sticky overflow accumulators scheduled round-robin onto one event channel
//
// Ports:
//   clock     in   1                 sole clock
//   reset     in   1                 asynchronous active-low reset
//   enable    in   1                 sink enable; low blocks new issues, accumulation continues
//   in_valid  in   NUM_CORES         per-core overflow report strobe
//   in_ovf    in   NUM_CORES*OVF_W   per-core vectors, core i at [i*OVF_W +: OVF_W]
//   evt       master modport         out_valid/out_ready/out_mhpmeventOverflow/out_coreid
//   pend_mask out  NUM_CORES         bit i set while core i has pending bits
module difftest_mhpm_ovf_sched
    import difftest_sched_pkg::*;
#(
    parameter int NUM_CORES   = 4,
    parameter int OVF_W       = difftest_sched_pkg::OVF_W,
    parameter int COREID_W    = difftest_sched_pkg::COREID_W,
    parameter int COREID_BASE = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NUM_CORES-1:0]       in_valid,
    input  logic [NUM_CORES*OVF_W-1:0] in_ovf,
    difftest_mhpm_ovf_sched_if.master  evt,
    output logic [NUM_CORES-1:0]       pend_mask
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [OVF_W-1:0]     pend [NUM_CORES];
    logic [NUM_CORES-1:0] req;
    logic [NUM_CORES-1:0] gnt;
    logic [PTR_W-1:0]     gnt_idx;
    logic [PTR_W-1:0]     ptr;
    logic                 any_req;
    logic                 slot_free;
    logic                 issue;

    // Requests come only from registered pend: a report in this cycle is seen next cycle.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            req[i] = |pend[i];
        end
    end

    assign pend_mask = req;
    assign slot_free = !evt.out_valid || evt.out_ready;
    assign issue     = enable && slot_free && any_req;

    rr_arbiter #(
        .N (NUM_CORES)
    ) u_arb (
        .req     (req),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any_req)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                pend[i] <= '0;
            end
            ptr                       <= '0;
            evt.out_valid             <= 1'b0;
            evt.out_mhpmeventOverflow <= '0;
            evt.out_coreid            <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (issue && gnt[i]) begin
                    // The granted vector leaves now; bits reported in the same cycle start a fresh accumulation.
                    pend[i] <= in_valid[i] ? in_ovf[i*OVF_W +: OVF_W] : '0;
                end else if (in_valid[i]) begin
                    pend[i] <= pend[i] | in_ovf[i*OVF_W +: OVF_W];
                end
            end

            if (issue) begin
                evt.out_valid             <= 1'b1;
                evt.out_mhpmeventOverflow <= pend[gnt_idx];
                evt.out_coreid            <= COREID_W'(COREID_BASE + int'(gnt_idx));
                ptr                       <= PTR_W'(rr_next(32'(gnt_idx), NUM_CORES));
            end else if (evt.out_ready) begin
                // Data and core id keep their last value once accepted.
                evt.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_difftest_mhpm_ovf_sched.sv
// tb/tb_difftest_mhpm_ovf_sched.sv - scoreboard bench for the mhpmevent overflow scheduler
module tb_difftest_mhpm_ovf_sched;
    import difftest_sched_pkg::*;

    localparam int NC = 4;

    typedef struct {
        logic [7:0] id;
        ovf_vec_t   vec;
    } ev_t;

    logic            clock;
    logic            reset;
    logic            enable;
    logic [NC-1:0]   in_valid;
    logic [NC*64-1:0] in_ovf;
    logic [NC-1:0]   pend_mask;

    int n_checks;
    int n_fail;
    ev_t exp_q[$];

    difftest_mhpm_ovf_sched_if #(.OVF_W(64), .COREID_W(8)) evt ();

    difftest_mhpm_ovf_sched #(
        .NUM_CORES   (NC),
        .OVF_W       (64),
        .COREID_W    (8),
        .COREID_BASE (0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ovf    (in_ovf),
        .evt       (evt),
        .pend_mask (pend_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rep(input int core, input ovf_vec_t v);
        in_valid[core]         = 1'b1;
        in_ovf[core*64 +: 64]  = v;
    endtask

    task automatic clr();
        in_valid = '0;
        in_ovf   = '0;
    endtask

    task automatic push(input logic [7:0] id, input ovf_vec_t v);
        ev_t e;
        e.id  = id;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !evt.out_valid) break;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Every accepted event is matched against the head of the expected queue.
    always @(negedge clock) begin
        if (reset && evt.out_valid && evt.out_ready) begin
            if (exp_q.size() == 0) begin
                check("evt_unexpected", 64'd1, 64'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("evt_id", 64'(evt.out_coreid), 64'(e.id));
                check("evt_vec", evt.out_mhpmeventOverflow, e.vec);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        enable   = 1'b1;
        evt.out_ready = 1'b1;
        clr();
        rep(0, 64'h1);

        // Reset state with a report held on the inputs
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_valid", 64'(evt.out_valid), 64'd0);
        check("rst_vec", evt.out_mhpmeventOverflow, 64'd0);
        check("rst_id", 64'(evt.out_coreid), 64'd0);
        check("rst_pend", 64'(pend_mask), 64'd0);
        push(8'd0, 64'h1);
        reset = 1'b1;
        step();
        clr();
        @(negedge clock);
        check("lat_t1_valid", 64'(evt.out_valid), 64'd0);
        check("lat_t1_pend", 64'(pend_mask), 64'b0001);
        @(negedge clock);
        check("lat_t2_valid", 64'(evt.out_valid), 64'd1);
        drain("drain_lat");

        // Core 3 alone brings ptr around to 0
        step();
        rep(3, 64'h100);
        push(8'd3, 64'h100);
        step();
        clr();
        drain("drain_wrap");

        // All four cores in one cycle, issued back to back
        step();
        rep(0, 64'h1); rep(1, 64'h2); rep(2, 64'h4); rep(3, 64'h8);
        push(8'd0, 64'h1); push(8'd1, 64'h2); push(8'd2, 64'h4); push(8'd3, 64'h8);
        step();
        clr();
        repeat (4) begin
            @(posedge clock);
            @(negedge clock);
            check("b2b_valid", 64'(evt.out_valid), 64'd1);
        end
        drain("drain_all4");
        check("all4_pend", 64'(pend_mask), 64'd0);

        // Coalescing while the slot is held by another event, plus output stability
        step();
        evt.out_ready = 1'b0;
        rep(0, 64'h1000);
        push(8'd0, 64'h1000);
        step();
        clr();
        rep(2, 64'h10);
        step();
        clr();
        rep(2, 64'h20);
        step();
        clr();
        repeat (5) begin
            @(negedge clock);
            check("hold_valid", 64'(evt.out_valid), 64'd1);
            check("hold_vec", evt.out_mhpmeventOverflow, 64'h1000);
            check("hold_id", 64'(evt.out_coreid), 64'd0);
        end
        check("hold_pend", 64'(pend_mask), 64'b0100);
        step();
        evt.out_ready = 1'b1;
        push(8'd2, 64'h30);
        drain("drain_merge");

        // Granted core reports again in its grant cycle
        step();
        rep(1, 64'hF0);
        push(8'd1, 64'hF0);
        push(8'd1, 64'h0F);
        step();
        rep(1, 64'h0F);
        step();
        clr();
        drain("drain_regrant");

        // enable low: no issue, accumulation continues
        step();
        enable = 1'b0;
        rep(0, 64'h1);
        step();
        rep(0, 64'h2);
        step();
        clr();
        rep(3, 64'h8);
        step();
        clr();
        repeat (3) begin
            @(negedge clock);
            check("dis_valid", 64'(evt.out_valid), 64'd0);
        end
        check("dis_pend", 64'(pend_mask), 64'b1001);
        step();
        enable = 1'b1;
        push(8'd3, 64'h8);
        push(8'd0, 64'h3);
        drain("drain_enable");

        // Reset in the middle of a stalled handshake
        step();
        evt.out_ready = 1'b0;
        rep(0, 64'h4000);
        step();
        clr();
        rep(1, 64'h2);
        rep(3, 64'h8);
        step();
        clr();
        @(negedge clock);
        check("mid_valid", 64'(evt.out_valid), 64'd1);
        check("mid_pend", 64'(pend_mask), 64'b1010);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 64'(evt.out_valid), 64'd0);
        check("mid_rst_pend", 64'(pend_mask), 64'd0);
        check("mid_rst_vec", evt.out_mhpmeventOverflow, 64'd0);
        step();
        step();
        reset = 1'b1;
        evt.out_ready = 1'b1;
        repeat (10) @(negedge clock);
        check("post_valid", 64'(evt.out_valid), 64'd0);
        check("post_pend", 64'(pend_mask), 64'd0);
        check("post_queue", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/difftest_mhpm_ovf_sched.md
Name: difftest_mhpm_ovf_sched

Overview:
Collects mhpmevent overflow bit-vectors from NUM_CORES cores and schedules them onto a single shared difftest MhpmeventOverflow event channel: valid, 64-bit overflow vector and 8-bit core id. Each core has a sticky pending accumulator. A round-robin scheduler issues one core's accumulated vector per accepted slot through a registered output stage with valid/ready backpressure. The block sits between core CSR units and the DPI event sink, so no overflow bit is lost when several cores report in the same cycle.

Parameters:
NUM_CORES, 4, number of requesting cores (2..16)
OVF_W, 64, overflow vector width
COREID_W, 8, core id width
COREID_BASE, 0, core id reported for requester 0; requester i reports COREID_BASE+i

Ports:
clock  in  1  sole clock
reset  in  1  asynchronous active-low reset
enable  in  1  sink enable; when low no new issue, accumulation continues
in_valid  in  NUM_CORES  per-core overflow report strobe
in_ovf  in  NUM_CORES*OVF_W  per-core overflow vectors, core i at [i*OVF_W +: OVF_W]
out_valid  out  1  event valid to sink
out_ready  in  1  sink accepts event this cycle
out_mhpmeventOverflow  out  OVF_W  issued overflow vector
out_coreid  out  COREID_W  issued core id
pend_mask  out  NUM_CORES  bit i set when pend[i] != 0 (registered state)

Behaviour:
- Reset: asynchronous on reset low. pend[*]=0, ptr=0, out_valid=0, out_mhpmeventOverflow=0, out_coreid=0; pend_mask=0 follows.
- Accumulate: if in_valid[i] is high, pend[i] <= pend[i] | in_ovf[i] unless core i is granted this cycle. in_valid with an all-zero vector changes nothing.
- req[i] = (pend[i] != 0). The cycle's in_ovf does not create a request until the following cycle; there is no bypass.
- slot_free = !out_valid || out_ready.
- issue = enable && slot_free && |req.
- Grant g: first requesting index at or after ptr, circular. On issue:
  - out_valid <= 1
  - out_mhpmeventOverflow <= pend[g]
  - out_coreid <= COREID_BASE+g, truncated to COREID_W
  - pend[g] <= in_valid[g] ? in_ovf[g] : 0, so same-cycle new bits are kept
  - ptr <= (g+1) mod NUM_CORES
- No issue and out_valid && out_ready: out_valid <= 0. Data/coreid hold their last value.
- out_valid && !out_ready: all out_* hold stable until accepted. No data change is permitted while out_valid is high and out_ready is low.
- enable low: no issue. An already-valid output still completes its handshake. ptr holds.
- Latency: report at cycle t gives out_valid at t+2 at the earliest (empty pend, free slot, ptr favourable). Back-to-back issue gives 1 event/cycle while out_ready=1.
- Fairness: a requesting core waits at most NUM_CORES-1 issues.
- ptr wraps from NUM_CORES-1 to 0.
- OR-merge means repeated reports before issue coalesce into one event; no drop condition exists.
- Reset asserted mid-handshake: output cleared immediately and all pending bits are discarded.

Decomposition:
- Shared package difftest_sched_pkg:
  - OVF_W and COREID_W default constants
  - typedef ovf_vec_t (logic [OVF_W-1:0])
  - function rr_next(ptr, n) for modular increment
- One sub-module, rr_arbiter:
  - Parameter N; inputs req[N] and ptr.
  - Outputs one-hot gnt, gnt_idx and any.
  - Purely combinational. ptr is stored in the parent.

Test Plan:
- Reset with in_valid=4'b0001, in_ovf[0]=64'h1 held, then release; enable=1, out_ready=1 -> out_valid rises 2 cycles after the first sampled report, out_coreid=0, out_mhpmeventOverflow=64'h1; all outputs are 0 while reset is low.
- All 4 cores report in one cycle (vectors 64'h1, 64'h2, 64'h4, 64'h8), out_ready=1 -> four consecutive events with coreid 0, 1, 2, 3 and matching vectors; pend_mask then 0.
- Core 2 reports 64'h10 at t and 64'h20 at t+1, out_ready=0 with the slot occupied by another event -> when the slot frees, one event: coreid 2, vector 64'h30.
- Granted core reports in its grant cycle: pend[1]=64'hF0, in_ovf[1]=64'h0F during issue -> event carries 64'hF0, then a later event carries 64'h0F.
- out_ready=0 for 5 cycles with out_valid=1 -> out_mhpmeventOverflow and out_coreid stable throughout; enable=0 with pending requests -> out_valid stays 0 and pend keeps accumulating.
- Assert reset for 1 cycle while out_valid=1 and pend_mask=4'b1010 -> out_valid=0 and pend_mask=0 immediately; no events afterwards without new reports.
